// File: rtl/imem_ctrl_pkg.sv
// rtl/imem_ctrl_pkg.sv - shared types and address helpers for imem_ctrl
//
// Purpose: state encoding, word-offset constant and the address helpers
// (word-index extraction, loader range check) shared by the imem_ctrl files.
// The helpers take the index width (log2 of the array depth) as an argument
// so they work for any power-of-two SIZE_IN_WORDS.
package imem_ctrl_pkg;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int WORD_LSB = 2;

  // Word index of a byte address; bits above the array index are cleared.
  function automatic logic [31:0] word_idx(input logic [31:0] addr, input int unsigned aw);
    logic [31:0] mask;
    mask = (32'd1 << aw) - 32'd1;
    return (addr >> WORD_LSB) & mask;
  endfunction

  // Word aligned and no bits set above the array's byte range.
  function automatic logic in_range(input logic [31:0] addr, input int unsigned aw);
    return ((addr >> (aw + WORD_LSB)) == 32'd0) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/imem_ctrl_sat_cnt.sv
// rtl/imem_ctrl_sat_cnt.sv - saturating up-counter with enable
//
// Purpose: counts enabled cycles, stopping at MAX.
// Ports:
//   ip_clk    clock
//   ip_reset  asynchronous active-high reset, clears the count
//   ip_en     count enable
//   op_count  current count
module imem_ctrl_sat_cnt #(
  parameter int WIDTH = 11,
  parameter int MAX   = 1024
) (
  input  logic             ip_clk,
  input  logic             ip_reset,
  input  logic             ip_en,
  output logic [WIDTH-1:0] op_count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (ip_en && (count_q != WIDTH'(MAX))) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge ip_clk or posedge ip_reset) begin
    if (ip_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign op_count = count_q;

endmodule

// File: rtl/imem_ctrl.sv
// rtl/imem_ctrl.sv - instruction memory boot-load / fetch sequencer
//
// Purpose: in LOAD the boot loader writes words into the imem array while the
// core is held in reset; ip_ld_done moves to RUN, where fetches get a
// registered one-cycle read. Only reset returns to LOAD.
// Build option: IMEM_CTRL_RUNTIME_WRITE_EN keeps the loader port open in RUN;
// a loader write then wins over a same-cycle fetch, which is stalled.
// Ports:
//   ip_clk, ip_reset                       clock, async active-high reset
//   ip_ld_valid/addr/data, op_ld_ready     loader write handshake
//   ip_ld_done                             end-of-load pulse
//   op_ld_err                              sticky bad-loader-address flag
//   op_loaded_words                        saturating count of loaded words
//   ip_fetch_req/addr                      core fetch request
//   op_fetch_valid/inst/stall              fetch response and stall
//   op_core_reset, op_boot_pc              core release and start address
//   op_mem_addr/we/wdata, ip_mem_rdata     single-port array interface
module imem_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int          SIZE_IN_WORDS = 1024,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000
) (
  input  logic                             ip_clk,
  input  logic                             ip_reset,
  input  logic                             ip_ld_valid,
  input  logic [31:0]                      ip_ld_addr,
  input  logic [31:0]                      ip_ld_data,
  output logic                             op_ld_ready,
  input  logic                             ip_ld_done,
  output logic                             op_ld_err,
  output logic [$clog2(SIZE_IN_WORDS):0]   op_loaded_words,
  input  logic                             ip_fetch_req,
  input  logic [31:0]                      ip_fetch_addr,
  output logic                             op_fetch_valid,
  output logic [31:0]                      op_fetch_inst,
  output logic                             op_fetch_stall,
  output logic                             op_core_reset,
  output logic [31:0]                      op_boot_pc,
  output logic [$clog2(SIZE_IN_WORDS)-1:0] op_mem_addr,
  output logic                             op_mem_we,
  output logic [31:0]                      op_mem_wdata,
  input  logic [31:0]                      ip_mem_rdata
);

  localparam int AW = $clog2(SIZE_IN_WORDS);

  state_e      state_q, state_d;
  logic        core_reset_q, core_reset_d;
  logic        ld_err_q, ld_err_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic [31:0] fetch_inst_q, fetch_inst_d;

  logic        is_load;
  logic        ld_ready;
  logic        ld_hs;
  logic        ld_in_range;
  logic        ld_we;
  logic        fetch_stall;
  logic        fetch_take;
  logic        cnt_en;
  logic [31:0] ld_idx_full;
  logic [31:0] fetch_idx_full;
  logic        unused_idx_bits;

  assign is_load = (state_q == ST_LOAD);

`ifdef IMEM_CTRL_RUNTIME_WRITE_EN
  assign ld_ready    = 1'b1;
  // Array is single-ported: a loader write in RUN takes the port and the
  // fetch is pushed back to the next cycle.
  assign fetch_stall = ~is_load & ip_fetch_req & ld_hs;
`else
  assign ld_ready    = is_load;
  assign fetch_stall = 1'b0;
`endif

  assign ld_hs          = ip_ld_valid & ld_ready;
  assign ld_in_range    = in_range(ip_ld_addr, AW);
  assign ld_we          = ld_hs & ld_in_range;
  assign fetch_take     = ~is_load & ip_fetch_req & ~fetch_stall;
  assign cnt_en         = is_load & ld_we;
  assign ld_idx_full    = word_idx(ip_ld_addr, AW);
  assign fetch_idx_full = word_idx(ip_fetch_addr, AW);
  assign unused_idx_bits = ^{ld_idx_full[31:AW], fetch_idx_full[31:AW]};

  always_comb begin
    state_d       = state_q;
    if (is_load && ip_ld_done) begin
      state_d = ST_RUN;
    end
    core_reset_d  = (state_d == ST_LOAD);
    ld_err_d      = ld_err_q | (ld_hs & ~ld_in_range);
    fetch_valid_d = fetch_take;
    // Hold register keeps the last delivered word on idle cycles.
    fetch_inst_d  = fetch_valid_q ? ip_mem_rdata : fetch_inst_q;
  end

  always_ff @(posedge ip_clk or posedge ip_reset) begin
    if (ip_reset) begin
      state_q       <= ST_LOAD;
      core_reset_q  <= 1'b1;
      ld_err_q      <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_inst_q  <= 32'd0;
    end else begin
      state_q       <= state_d;
      core_reset_q  <= core_reset_d;
      ld_err_q      <= ld_err_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_inst_q  <= fetch_inst_d;
    end
  end

  imem_ctrl_sat_cnt #(
    .WIDTH (AW + 1),
    .MAX   (SIZE_IN_WORDS)
  ) u_loaded_cnt (
    .ip_clk   (ip_clk),
    .ip_reset (ip_reset),
    .ip_en    (cnt_en),
    .op_count (op_loaded_words)
  );

  // Array read data arrives the cycle after the address, so the valid word is
  // passed straight through rather than re-registered.
  assign op_fetch_inst  = fetch_valid_q ? ip_mem_rdata : fetch_inst_q;
  assign op_fetch_valid = fetch_valid_q;
  assign op_fetch_stall = fetch_stall;
  assign op_ld_ready    = ld_ready;
  assign op_ld_err      = ld_err_q;
  assign op_core_reset  = core_reset_q;
  assign op_boot_pc     = RESET_PC;
  assign op_mem_addr    = ld_hs ? ld_idx_full[AW-1:0] : fetch_idx_full[AW-1:0];
  assign op_mem_we      = ld_we;
  assign op_mem_wdata   = ip_ld_data;

endmodule

// File: doc/imem_ctrl.md
Name: imem_ctrl

Overview:
- Sequences the instruction memory through two phases: boot load, then fetch service.
- During LOAD it accepts word writes from the boot loader over a valid/ready handshake and holds the core in reset.
- During RUN it serves fetch requests with a registered, one-cycle read, and optionally lets the loader patch memory at runtime.
- Sits between the core fetch stage, the boot loader and a single-port imem array.

Parameters:
- SIZE_IN_WORDS, 1024, depth of the imem array in 32-bit words; must be a power of two.
- RESET_PC, 32'h0000_0000, value reported on op_boot_pc when the core is released.

Ports:
- ip_clk  input  1  clock.
- ip_reset  input  1  asynchronous, active-high reset.
- ip_ld_valid  input  1  loader write request.
- ip_ld_addr  input  32  loader byte address.
- ip_ld_data  input  32  loader write word.
- op_ld_ready  output  1  loader write accepted this cycle when high together with ip_ld_valid.
- ip_ld_done  input  1  one-cycle pulse ending the load phase.
- op_ld_err  output  1  sticky flag: an out-of-range or misaligned loader write was seen.
- op_loaded_words  output  $clog2(SIZE_IN_WORDS)+1  count of accepted in-range writes, saturating.
- ip_fetch_req  input  1  fetch request.
- ip_fetch_addr  input  32  fetch byte address.
- op_fetch_valid  output  1  op_fetch_inst is valid.
- op_fetch_inst  output  32  fetched instruction.
- op_fetch_stall  output  1  request this cycle not taken; core must hold ip_fetch_addr.
- op_core_reset  output  1  holds the core in reset.
- op_boot_pc  output  32  equals RESET_PC.
- op_mem_addr  output  $clog2(SIZE_IN_WORDS)  word index to the array.
- op_mem_we  output  1  array write enable.
- op_mem_wdata  output  32  array write data.
- ip_mem_rdata  input  32  array read data, valid one cycle after op_mem_addr.

Behaviour:
- Reset values: state=LOAD, op_core_reset=1, op_ld_ready=1, op_ld_err=0, op_loaded_words=0, op_fetch_valid=0, op_fetch_inst=0, op_fetch_stall=0, op_mem_we=0.
- Reset is asynchronous. Memory contents are not cleared by reset.
- Address rules:
  - Word index = addr[$clog2(SIZE_IN_WORDS)+1:2].
  - A loader address is in range when addr[31:$clog2(SIZE_IN_WORDS)+2]==0 and addr[1:0]==0.
- LOAD state:
  - op_ld_ready=1.
  - A handshake with an in-range address drives op_mem_we=1 the same cycle (combinational), and op_loaded_words increments, saturating at SIZE_IN_WORDS.
  - A handshake with an out-of-range or misaligned address suppresses op_mem_we, does not count, and sets op_ld_err, which stays set until reset.
  - ip_fetch_req is ignored: op_fetch_valid=0, op_fetch_stall=0.
- LOAD to RUN:
  - ip_ld_done moves the state to RUN at the next edge.
  - A handshake coinciding with ip_ld_done is still written and counted.
  - op_core_reset goes to 0 on the first RUN cycle (registered).
- RUN state:
  - ip_fetch_req drives op_mem_addr from ip_fetch_addr combinationally.
  - On the next cycle op_fetch_valid=1 and op_fetch_inst=ip_mem_rdata.
  - Back-to-back requests give one instruction per cycle.
  - ip_fetch_addr[1:0] is ignored.
  - Cycles without a request give op_fetch_valid=0; op_fetch_inst holds its last value.
  - ip_ld_done in RUN has no effect. The only way back to LOAD is reset.
- FSM: LOAD -> RUN on ip_ld_done; RUN has no exit except reset.

Optional Feature:
- Macro: IMEM_CTRL_RUNTIME_WRITE_EN.
- Defined:
  - op_ld_ready=1 in RUN as well.
  - A loader write has priority over a fetch in the same cycle. The write is performed, op_fetch_stall=1, and op_fetch_valid=0 on the following cycle.
  - The core re-presents the same fetch address next cycle.
  - Range checks and op_ld_err apply as in LOAD; op_loaded_words is not incremented in RUN.
- Undefined:
  - op_ld_ready=0 in RUN.
  - op_fetch_stall is tied to 0.

Decomposition:
- Package imem_ctrl_pkg holds:
  - state encoding (ST_LOAD=1'b0, ST_RUN=1'b1);
  - WORD_LSB=2;
  - functions for word-index extraction and range check, parameterised by SIZE_IN_WORDS.
- One sub-module: imem_ctrl_sat_cnt, a saturating up-counter with enable and async reset, used for op_loaded_words.

Test Plan:
- Reset, then write words 0..3 (data 32'h00000013+i) with ip_ld_valid held high -> op_mem_we high for 4 cycles, op_loaded_words=4, op_core_reset=1.
- Loader write to 32'h0000_1000 (SIZE 1024) and to 32'h0000_0002 -> no op_mem_we, op_ld_err=1 and stays set.
- ip_ld_done together with a write to addr 0x10 -> write performed, op_loaded_words increments, op_core_reset=0 on the next cycle.
- RUN: fetch 0x0, 0x4, 0x8 back-to-back -> op_fetch_valid high on cycles 1-3 with the stored words in order.
- With IMEM_CTRL_RUNTIME_WRITE_EN, loader write plus fetch in the same cycle -> op_fetch_stall=1, write done, no op_fetch_valid next cycle, retried fetch returns the new data.
- Assert ip_reset mid-load after 2 writes -> all outputs return to reset values immediately, op_loaded_words=0, state=LOAD.
